// File: rtl/vedic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vedic_pkg
//  Description : Shared constants and elaboration-time helpers for the
//                pipelined Vedic multiplier. The helpers size the leaf grid,
//                the number of combine levels and the packed layout of the
//                per-level sub-product bus.
//  Revision    : 1.0 - initial release
// ============================================================================
package vedic_pkg;

    // Operand width handled by one Urdhva-Tiryagbhyam leaf.
    localparam int LEAF_W = 4;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Number of recursive combine levels above the 4x4 leaves.
    function automatic int num_levels(input int width);
        return clog2(width / LEAF_W);
    endfunction

    // Total bits of all sub-products held at level k. Level k holds
    // (width/n)^2 products of 2n bits, where n = LEAF_W << k.
    function automatic int lvl_bits(input int width, input int k);
        return (2 * width * width) / (LEAF_W << k);
    endfunction

    // Bit offset of level k inside the concatenated sub-product bus.
    function automatic int lvl_off(input int width, input int k);
        int s;
        s = 0;
        for (int j = 0; j < k; j++) begin
            s = s + lvl_bits(width, j);
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vedic_4bits.sv
`default_nettype none
// ============================================================================
//  Module      : vedic_4bits
//  Description : Combinational 4x4 unsigned Urdhva-Tiryagbhyam multiplier.
//                Each output column sums the vertical/crosswise partial
//                products whose bit indices add up to that column.
//  Ports       : i_a [3:0]  multiplicand
//                i_b [3:0]  multiplier
//                o_p [7:0]  unsigned product
//  Revision    : 1.0 - initial release
// ============================================================================
module vedic_4bits (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_p
);

    // Column sums, each sized to its largest possible count.
    logic       w_c0;
    logic [1:0] w_c1;
    logic [1:0] w_c2;
    logic [2:0] w_c3;
    logic [1:0] w_c4;
    logic [1:0] w_c5;
    logic       w_c6;

    assign w_c0 = i_a[0] & i_b[0];
    assign w_c1 = {1'b0, i_a[1] & i_b[0]} + {1'b0, i_a[0] & i_b[1]};
    assign w_c2 = {1'b0, i_a[2] & i_b[0]} + {1'b0, i_a[1] & i_b[1]}
                + {1'b0, i_a[0] & i_b[2]};
    assign w_c3 = {2'b00, i_a[3] & i_b[0]} + {2'b00, i_a[2] & i_b[1]}
                + {2'b00, i_a[1] & i_b[2]} + {2'b00, i_a[0] & i_b[3]};
    assign w_c4 = {1'b0, i_a[3] & i_b[1]} + {1'b0, i_a[2] & i_b[2]}
                + {1'b0, i_a[1] & i_b[3]};
    assign w_c5 = {1'b0, i_a[3] & i_b[2]} + {1'b0, i_a[2] & i_b[3]};
    assign w_c6 = i_a[3] & i_b[3];

    // Weighted sum of the columns resolves all carries.
    assign o_p = {7'b0, w_c0}
               + {5'b0, w_c1, 1'b0}
               + {4'b0, w_c2, 2'b0}
               + {2'b0, w_c3, 3'b0}
               + {2'b0, w_c4, 4'b0}
               + {1'b0, w_c5, 5'b0}
               + {1'b0, w_c6, 6'b0};

endmodule
`default_nettype wire

// File: rtl/vedic_combine.sv
`default_nettype none
// ============================================================================
//  Module      : vedic_combine
//  Description : Combinational recombination of four N x N sub-products into
//                one 2N x 2N product: P = ll + (hl << N) + (lh << N) +
//                (hh << 2N). All terms are zero-extended to 4N bits, which
//                is exactly wide enough for the full product.
//  Ports       : i_ll [2N-1:0]  low(A)  x low(B)
//                i_hl [2N-1:0]  high(A) x low(B)
//                i_lh [2N-1:0]  low(A)  x high(B)
//                i_hh [2N-1:0]  high(A) x high(B)
//                o_p  [4N-1:0]  combined product
//  Revision    : 1.0 - initial release
// ============================================================================
module vedic_combine #(
    parameter int N = 4
) (
    input  logic [2*N-1:0] i_ll,
    input  logic [2*N-1:0] i_hl,
    input  logic [2*N-1:0] i_lh,
    input  logic [2*N-1:0] i_hh,
    output logic [4*N-1:0] o_p
);

    assign o_p = {{(2*N){1'b0}}, i_ll}
               + {{N{1'b0}}, i_hl, {N{1'b0}}}
               + {{N{1'b0}}, i_lh, {N{1'b0}}}
               + {i_hh, {(2*N){1'b0}}};

endmodule
`default_nettype wire

// File: rtl/vedic_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : vedic_mul_pipe
//  Description : Pipelined signed/unsigned Vedic multiplier with valid/ready
//                handshake and sideband tag. Stages:
//                  S1      operand magnitudes, result sign, tag
//                  S2      all 4x4 leaf products
//                  S3..    one register per recursive combine level
//                  final   conditional negation into Q
//                Latency is 3 + log2(WIDTH/4) cycles. A single global enable
//                (output empty or being taken) advances every stage at once,
//                so bubbles move with the data and are never squeezed out.
//                IN_READY therefore depends combinationally on OUT_READY.
//  Ports       : CLK, RST             clock, synchronous active-high reset
//                IN_VALID/IN_READY    operand handshake
//                A, B [WIDTH-1:0]     operands
//                SIGNED               1 = two's complement operands
//                TAG [TAG_W-1:0]      sideband id returned with the result
//                OUT_VALID/OUT_READY  result handshake
//                Q [2*WIDTH-1:0]      product
//                OUT_TAG [TAG_W-1:0]  tag of the product on Q
//                BUSY                 any stage holds a valid operation
//  Revision    : 1.0 - initial release
// ============================================================================
module vedic_mul_pipe
    import vedic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               SIGNED,
    input  logic [TAG_W-1:0]   TAG,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [2*WIDTH-1:0] Q,
    output logic [TAG_W-1:0]   OUT_TAG,
    output logic               BUSY
);

    localparam int LEVELS  = num_levels(WIDTH);
    localparam int NSTG    = 3 + LEVELS;
    localparam int GL      = WIDTH / LEAF_W;
    localparam int L0_BITS = lvl_bits(WIDTH, 0);
    localparam int TOTAL   = lvl_off(WIDTH, LEVELS + 1);
    localparam int FIN_OFF = lvl_off(WIDTH, LEVELS);

    logic                 w_en;
    logic                 w_acc;
    logic                 w_neg;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [L0_BITS-1:0]   w_leaf;
    logic [TOTAL-1:0]     w_lvl;     // registered sub-products of every level
    logic [2*WIDTH-1:0]   w_pfin;

    logic [NSTG-1:0]      r_vld;     // r_vld[NSTG-1] is OUT_VALID
    logic [NSTG-2:0]      r_neg;     // sign travels with its operands
    logic [TAG_W-1:0]     r_tag [NSTG];
    logic [WIDTH-1:0]     r_mag_a;
    logic [WIDTH-1:0]     r_mag_b;
    logic [L0_BITS-1:0]   r_leaf;
    logic [2*WIDTH-1:0]   r_q;

    assign w_en     = ~r_vld[NSTG-1] | OUT_READY;
    assign IN_READY = w_en;
    assign w_acc    = IN_VALID & w_en;

    // Magnitudes: the most negative operand maps to 2^(WIDTH-1), which still
    // fits in WIDTH unsigned bits, so no extra width is needed.
    assign w_neg   = SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);
    assign w_mag_a = (SIGNED & A[WIDTH-1]) ? -A : A;
    assign w_mag_b = (SIGNED & B[WIDTH-1]) ? -B : B;

    // Control, S1 and final stage.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_vld   <= '0;
            r_neg   <= '0;
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_q     <= '0;
            for (int s = 0; s < NSTG; s++) begin
                r_tag[s] <= '0;
            end
        end else if (w_en) begin
            r_vld    <= {r_vld[NSTG-2:0], w_acc};
            r_neg    <= {r_neg[NSTG-3:0], w_neg};
            r_tag[0] <= TAG;
            for (int s = 1; s < NSTG; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
            r_mag_a  <= w_mag_a;
            r_mag_b  <= w_mag_b;
            r_q      <= r_neg[NSTG-2] ? -w_pfin : w_pfin;
        end
    end

    // S2: leaf grid. Leaf (i, j) multiplies nibble i of |A| by nibble j of |B|.
    for (genvar gi = 0; gi < GL; gi++) begin : g_leaf_row
        for (genvar gj = 0; gj < GL; gj++) begin : g_leaf_col
            vedic_4bits u_leaf (
                .i_a (r_mag_a[gi*LEAF_W +: LEAF_W]),
                .i_b (r_mag_b[gj*LEAF_W +: LEAF_W]),
                .o_p (w_leaf[(gi*GL + gj)*2*LEAF_W +: 2*LEAF_W])
            );
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_leaf <= '0;
        end else if (w_en) begin
            r_leaf <= w_leaf;
        end
    end

    assign w_lvl[0 +: L0_BITS] = r_leaf;

    // S3..: each level merges 2x2 neighbouring blocks of the level below.
    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
        localparam int N    = LEAF_W << (k - 1);   // sub-operand width below
        localparam int G    = WIDTH / (2 * N);      // grid size at this level
        localparam int GP   = 2 * G;                // grid size below
        localparam int POFF = lvl_off(WIDTH, k - 1);
        localparam int COFF = lvl_off(WIDTH, k);
        localparam int BITS = lvl_bits(WIDTH, k);

        logic [BITS-1:0] w_c;
        logic [BITS-1:0] r_c;

        for (genvar gi = 0; gi < G; gi++) begin : g_row
            for (genvar gj = 0; gj < G; gj++) begin : g_col
                vedic_combine #(.N(N)) u_comb (
                    .i_ll (w_lvl[POFF + ((2*gi)  *GP + 2*gj  )*2*N +: 2*N]),
                    .i_hl (w_lvl[POFF + ((2*gi+1)*GP + 2*gj  )*2*N +: 2*N]),
                    .i_lh (w_lvl[POFF + ((2*gi)  *GP + 2*gj+1)*2*N +: 2*N]),
                    .i_hh (w_lvl[POFF + ((2*gi+1)*GP + 2*gj+1)*2*N +: 2*N]),
                    .o_p  (w_c[(gi*G + gj)*4*N +: 4*N])
                );
            end
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                r_c <= '0;
            end else if (w_en) begin
                r_c <= w_c;
            end
        end

        assign w_lvl[COFF +: BITS] = r_c;
    end

    assign w_pfin    = w_lvl[FIN_OFF +: 2*WIDTH];

    assign Q         = r_q;
    assign OUT_VALID = r_vld[NSTG-1];
    assign OUT_TAG   = r_tag[NSTG-1];
    assign BUSY      = |r_vld;

endmodule
`default_nettype wire

// File: tb/tb_vedic_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vedic_mul_pipe
//  Description : Self-checking bench for vedic_mul_pipe at WIDTH=16 and
//                WIDTH=8. Expected products come from plain integer
//                multiplication; a queue per instance holds results in
//                acceptance order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vedic_mul_pipe;

    logic        clk = 1'b0;
    logic        rst;

    logic        iv16, ir16, s16, ov16, or16, busy16;
    logic [15:0] a16, b16;
    logic [3:0]  t16, ot16;
    logic [31:0] q16;

    logic        iv8, ir8, s8, ov8, or8, busy8;
    logic [7:0]  a8, b8;
    logic [3:0]  t8, ot8;
    logic [15:0] q8;

    typedef struct packed { logic [31:0] q; logic [3:0] tag; } e16_t;
    typedef struct packed { logic [15:0] q; logic [3:0] tag; } e8_t;

    e16_t sb16[$];
    e8_t  sb8[$];

    int n_chk  = 0;
    int n_pass = 0;
    int n_out16 = 0;
    int n_out8  = 0;

    always #5 clk = ~clk;

    vedic_mul_pipe #(.WIDTH(16), .TAG_W(4)) dut16 (
        .CLK(clk), .RST(rst), .IN_VALID(iv16), .IN_READY(ir16),
        .A(a16), .B(b16), .SIGNED(s16), .TAG(t16),
        .OUT_VALID(ov16), .OUT_READY(or16), .Q(q16), .OUT_TAG(ot16),
        .BUSY(busy16)
    );

    vedic_mul_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (
        .CLK(clk), .RST(rst), .IN_VALID(iv8), .IN_READY(ir8),
        .A(a8), .B(b8), .SIGNED(s8), .TAG(t8),
        .OUT_VALID(ov8), .OUT_READY(or8), .Q(q8), .OUT_TAG(ot8),
        .BUSY(busy8)
    );

    function automatic logic [31:0] mdl16(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic s);
        longint x, y;
        logic [63:0] p;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        p = 64'(x * y);
        return p[31:0];
    endfunction

    function automatic logic [15:0] mdl8(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic s);
        longint x, y;
        logic [63:0] p;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        p = 64'(x * y);
        return p[15:0];
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 7))
            0:       return 16'h8000;
            1:       return 16'hFFFF;
            2:       return 16'h0000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock cycle: handshakes are evaluated at the falling edge, when
    // the inputs driven after the previous rising edge are stable.
    task automatic step();
        e16_t e;
        e8_t  f;
        @(negedge clk);
        if (rst) begin
            sb16.delete();
            sb8.delete();
        end else begin
            if (ov16 && or16) begin
                chk("sb16_expected", 64'(sb16.size() != 0), 64'd1);
                if (sb16.size() != 0) begin
                    e = sb16.pop_front();
                    chk("q16", 64'(q16), 64'(e.q));
                    chk("tag16", 64'(ot16), 64'(e.tag));
                    n_out16++;
                end
            end
            if (iv16 && ir16) sb16.push_back(e16_t'{mdl16(a16, b16, s16), t16});
            if (ov8 && or8) begin
                chk("sb8_expected", 64'(sb8.size() != 0), 64'd1);
                if (sb8.size() != 0) begin
                    f = sb8.pop_front();
                    chk("q8", 64'(q8), 64'(f.q));
                    chk("tag8", 64'(ot8), 64'(f.tag));
                    n_out8++;
                end
            end
            if (iv8 && ir8) sb8.push_back(e8_t'{mdl8(a8, b8, s8), t8});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out16(input int start, output int lat);
        lat = start;
        while (!ov16 && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic wait_out8(input int start, output int lat);
        lat = start;
        while (!ov8 && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (sb16.size() != 0 || sb8.size() != 0); i++) begin
            step();
        end
        chk("drain_empty16", 64'(sb16.size()), 64'd0);
        chk("drain_empty8", 64'(sb8.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int n0;
        int qsz;
        logic [15:0] da [6];
        logic [15:0] db [6];
        logic        ds [6];

        rst = 1'b1;
        iv16 = 0; a16 = 0; b16 = 0; s16 = 0; t16 = 0; or16 = 1;
        iv8  = 0; a8  = 0; b8  = 0; s8  = 0; t8  = 0; or8  = 1;
        repeat (3) step();
        rst = 1'b0;

        // Reset state
        chk("rst_ov16", 64'(ov16), 64'd0);
        chk("rst_busy16", 64'(busy16), 64'd0);
        chk("rst_q16", 64'(q16), 64'd0);
        chk("rst_tag16", 64'(ot16), 64'd0);
        chk("rst_ir16", 64'(ir16), 64'd1);
        chk("rst_ov8", 64'(ov8), 64'd0);
        chk("rst_q8", 64'(q8), 64'd0);

        // Unsigned max * max, latency 5
        iv16 = 1; a16 = 16'hFFFF; b16 = 16'hFFFF; s16 = 0; t16 = 4'h5;
        step();
        iv16 = 0;
        wait_out16(1, lat);
        chk("t1_lat", 64'(lat), 64'd5);
        chk("t1_q", 64'(q16), 64'h0000_0000_FFFE_0001);
        chk("t1_tag", 64'(ot16), 64'h5);
        chk("t1_busy", 64'(busy16), 64'd1);
        step();

        // Signed most-negative squared, then -1 * 3 back to back
        iv16 = 1; a16 = 16'h8000; b16 = 16'h8000; s16 = 1; t16 = 4'h2;
        step();
        a16 = 16'hFFFF; b16 = 16'h0003; t16 = 4'h3;
        step();
        iv16 = 0;
        wait_out16(2, lat);
        chk("t2_lat", 64'(lat), 64'd5);
        chk("t2_q_min", 64'(q16), 64'h4000_0000);
        chk("t2_tag_min", 64'(ot16), 64'h2);
        step();
        chk("t2_b2b_ov", 64'(ov16), 64'd1);
        chk("t2_q_m3", 64'(q16), 64'hFFFF_FFFD);
        chk("t2_tag_m3", 64'(ot16), 64'h3);
        drain();

        // Zero operands and signed extremes, back to back
        da = '{16'h0000, 16'h0000, 16'hABCD, 16'h7FFF, 16'h8000, 16'hFFFF};
        db = '{16'h1234, 16'h8000, 16'h0000, 16'h7FFF, 16'h7FFF, 16'hFFFF};
        ds = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            iv16 = 1; a16 = da[i]; b16 = db[i]; s16 = ds[i]; t16 = 4'(i + 8);
            step();
        end
        iv16 = 0;
        drain();

        // 200-operand random stream at full throughput; WIDTH=8 instance
        // sees random traffic with random backpressure at the same time.
        n0 = n_out16;
        for (int i = 0; i < 200; i++) begin
            iv16 = 1; a16 = rnd16(); b16 = rnd16(); s16 = 1'($urandom);
            t16 = 4'($urandom);
            iv8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
            s8 = 1'($urandom); t8 = 4'($urandom);
            or8 = ($urandom_range(0, 3) != 0);
            step();
        end
        iv16 = 0; iv8 = 0; or8 = 1;
        chk("t3_stream_cnt", 64'(n_out16 - n0), 64'd195);
        drain();
        chk("t3_total", 64'(n_out16 - n0), 64'd200);

        // Fill, then stall for 7 cycles
        for (int i = 0; i < 8; i++) begin
            iv16 = 1; a16 = rnd16(); b16 = rnd16(); s16 = 1'($urandom);
            t16 = 4'(i);
            step();
        end
        for (int i = 0; i < 7; i++) begin
            or16 = 0; iv16 = 1; a16 = rnd16(); b16 = rnd16(); t16 = 4'hF;
            #1;
            chk("t4_ir", 64'(ir16), 64'd0);
            step();
            chk("t4_ov", 64'(ov16), 64'd1);
            chk("t4_q_hold", 64'(q16), 64'(sb16[0].q));
            chk("t4_tag_hold", 64'(ot16), 64'(sb16[0].tag));
        end
        or16 = 1; iv16 = 0;
        qsz = sb16.size();
        n0 = n_out16;
        drain();
        chk("t4_release_cnt", 64'(n_out16 - n0), 64'(qsz));

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) begin
            iv16 = 1; a16 = rnd16(); b16 = rnd16(); s16 = 1'($urandom);
            t16 = 4'(i + 1);
            step();
        end
        iv16 = 0; rst = 1;
        step();
        rst = 0;
        chk("t5_ov", 64'(ov16), 64'd0);
        chk("t5_busy", 64'(busy16), 64'd0);
        chk("t5_q", 64'(q16), 64'd0);
        n0 = n_out16;
        repeat (10) step();
        chk("t5_no_stale", 64'(n_out16 - n0), 64'd0);
        chk("t5_busy_idle", 64'(busy16), 64'd0);
        iv16 = 1; a16 = 16'h1234; b16 = 16'h00FF; s16 = 0; t16 = 4'h7;
        step();
        iv16 = 0;
        wait_out16(1, lat);
        chk("t5_fresh_lat", 64'(lat), 64'd5);
        chk("t5_fresh_q", 64'(q16), 64'h0012_21CC);
        drain();

        // WIDTH=8: 0xC8 * 0x0F in both modes, latency 4
        iv8 = 1; a8 = 8'hC8; b8 = 8'h0F; s8 = 0; t8 = 4'h9;
        step();
        iv8 = 0;
        wait_out8(1, lat);
        chk("t6_lat_u", 64'(lat), 64'd4);
        chk("t6_q_u", 64'(q8), 64'h0BB8);
        chk("t6_tag_u", 64'(ot8), 64'h9);
        step();
        iv8 = 1; a8 = 8'hC8; b8 = 8'h0F; s8 = 1; t8 = 4'hA;
        step();
        iv8 = 0;
        wait_out8(1, lat);
        chk("t6_lat_s", 64'(lat), 64'd4);
        chk("t6_q_s", 64'(q8), 64'hFCB8);
        chk("t6_tag_s", 64'(ot8), 64'hA);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
